life_frame_buffer: RTL and testbench
====================================

# life_frame_buffer

Double-buffered cell memory that sits directly upstream of the VGA timing stage. It serves that stage's packed-cell reads from the displayed (front) bank with one-cycle latency. It accepts next-generation writes from the evolution engine into the back bank and swaps banks only at the vertical-sync leading edge, so a frame never tears. It also performs single-cell toggle edits on the front bank for manual setting mode.

## Interface
Parameters:
- `ADDR_W`, default 14: word-address width; each bank holds `DEPTH` words.
- `DEPTH`, default 16384: words per bank; must be ≤ 2^ADDR_W.
- `BLOCK_LEN`, default 32: cells per word; fixed at 32 (cell index = {word, bit[4:0]}).
- `VSPP`, default 0: vsync active polarity (0 negative, 1 positive).

Ports:
- `clk` in, 1: system/pixel clock; all logic on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `vga_addr` in, ADDR_W: display word address.
- `vga_live` out, BLOCK_LEN: front-bank word at `vga_addr` from the previous cycle.
- `vsync` in, 1: sync from the VGA stage; its active edge is the swap point.
- `eng_start` in, 1: pulse requesting a generation.
- `eng_done` in, 1: pulse signalling the generation is fully written.
- `eng_rd_addr` in, ADDR_W: engine read address (front bank).
- `eng_rd_data` out, BLOCK_LEN: registered front-bank word.
- `eng_wr_en` in, 1: engine write strobe (back bank).
- `eng_wr_addr` in, ADDR_W: engine write address.
- `eng_wr_data` in, BLOCK_LEN: engine write data.
- `edit_req` in, 1: pulse requesting a toggle of one cell.
- `edit_pos` in, ADDR_W+5: cell index to toggle.
- `ready` out, 1: high in IDLE only.
- `eng_busy` out, 1: high in RUN.
- `swapped` out, 1: one-cycle pulse when the banks swap.
- `front_sel` out, 1: index of the displayed bank.

## Operation
- Two banks, B0/B1; front = B[front_sel], back = B[~front_sel]. Contents are zero at configuration and not cleared by `rst`.
- Display read: `vga_live` <= front[vga_addr] every cycle in every state.
- Engine read: `eng_rd_data` <= front[eng_rd_addr] every cycle.
- Out-of-range (addr ≥ DEPTH) reads return 0; out-of-range writes are dropped.
- FSM states: IDLE, RUN, SWAP_WAIT, EDIT_RD, EDIT_WR.
  - IDLE: `edit_req` -> EDIT_RD, latching `edit_pos`. Else `eng_start` -> RUN. If both arrive together, edit wins and `eng_start` is dropped.
  - RUN: `eng_wr_en` writes back[eng_wr_addr]. `eng_done` -> SWAP_WAIT; a write in the same cycle as `eng_done` is still performed. `edit_req` and `eng_start` are ignored.
  - SWAP_WAIT: on a vsync leading edge (vsync_q != VSPP and vsync == VSPP, with vsync_q the registered vsync), toggle `front_sel`, pulse `swapped`, -> IDLE. Engine writes are ignored.
  - EDIT_RD: read front[edit_pos[ADDR_W+4:5]] into an internal register, -> EDIT_WR.
  - EDIT_WR: write that word back with bit edit_pos[4:0] inverted, -> IDLE. Out-of-range edits are a no-op and still return to IDLE.
- `eng_wr_en` outside RUN is ignored.
- `eng_done` outside RUN is ignored.
- vsync edges outside SWAP_WAIT have no effect.
- Reset: async to IDLE, `front_sel`=0, `vga_live`=0, `eng_rd_data`=0, `swapped`=0, `eng_busy`=0, `ready`=1 after release, vsync_q = ~VSPP. A pending swap or edit is abandoned; memory is retained.

## Timing
- Read latency is 1 cycle on both read ports. Reads address the bank selected by `front_sel` at the sampling edge.
- Swap point:
  - Edge detected in cycle N.
  - `front_sel` and `swapped` update at the end of N.
  - The first read from the new front bank is the address presented in N+1, with data visible in N+2.
- An edit takes 3 cycles from `edit_req` sampling to `ready` high:
  - IDLE -> EDIT_RD -> EDIT_WR -> IDLE.
  - The toggled word is readable on `vga_live` 2 cycles after the EDIT_WR edge.
- An engine write in cycle N to the back bank is visible only after a swap. It never appears on `vga_live` before `swapped`.
- A read and a write to the same front address in the same cycle (EDIT_WR) return old data.

## Test plan
- Reset, write B1 via engine (RUN, addr 5 = 0xDEADBEEF, `eng_done`), toggle vsync -> `swapped` pulses once, `front_sel`=1, `vga_live`=0xDEADBEEF one cycle after `vga_addr`=5.
- In SWAP_WAIT, hold vsync inactive 1000 cycles -> `front_sel` unchanged, `ready`=0, engine writes to addr 7 ignored.
- `edit_req` with `edit_pos`={addr 3, bit 31} on a zero word -> front[3]=0x80000000 after 3 cycles; repeat -> 0x00000000.
- `edit_req` and `eng_start` in the same cycle -> FSM goes EDIT_RD, `eng_busy` stays 0; `eng_start` 3 cycles later -> `eng_busy`=1.
- Assert `rst` mid-RUN and mid-SWAP_WAIT -> immediate IDLE, `front_sel`=0, no `swapped`, previously written words retained.
- Read/write addr ≥ DEPTH (DEPTH=1000, addr 1000) -> `vga_live`=0, memory unchanged.

Source files
------------

// File: rtl/life_frame_buffer.sv
// rtl/life_frame_buffer.sv - double-buffered Life cell memory with vsync-aligned bank swap
// Display and engine reads come from the front bank; engine writes go to the back bank; edits toggle front cells.
module life_frame_buffer #(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 16384,
  parameter int BLOCK_LEN = 32,
  parameter int VSPP      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    vga_addr,
  output logic [BLOCK_LEN-1:0] vga_live,
  input  logic                 vsync,
  input  logic                 eng_start,
  input  logic                 eng_done,
  input  logic [ADDR_W-1:0]    eng_rd_addr,
  output logic [BLOCK_LEN-1:0] eng_rd_data,
  input  logic                 eng_wr_en,
  input  logic [ADDR_W-1:0]    eng_wr_addr,
  input  logic [BLOCK_LEN-1:0] eng_wr_data,
  input  logic                 edit_req,
  input  logic [ADDR_W+4:0]    edit_pos,
  output logic                 ready,
  output logic                 eng_busy,
  output logic                 swapped,
  output logic                 front_sel
);

  localparam logic              VS_ACT  = (VSPP != 0);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SWAP_WAIT,
    S_EDIT_RD,
    S_EDIT_WR
  } state_t;

  state_t               state_q, state_d;
  logic                 front_sel_q, front_sel_d;
  logic                 swapped_q, swapped_d;
  logic                 vsync_q;
  logic [ADDR_W+4:0]    edit_pos_q, edit_pos_d;
  logic [BLOCK_LEN-1:0] edit_word_q, edit_word_d;
  logic [BLOCK_LEN-1:0] vga_live_q, eng_rd_q;

  logic [BLOCK_LEN-1:0] bank0_q [DEPTH];
  logic [BLOCK_LEN-1:0] bank1_q [DEPTH];

  logic                 wr_en;
  logic                 wr_bank;
  logic [ADDR_W-1:0]    wr_addr;
  logic [BLOCK_LEN-1:0] wr_data;

  logic [ADDR_W-1:0]    edit_addr;
  logic [BLOCK_LEN-1:0] toggle_mask;
  logic                 vsync_lead;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  // Out-of-range addresses read as zero rather than aliasing into the bank.
  function automatic logic [BLOCK_LEN-1:0] rd_front(input logic [ADDR_W-1:0] a);
    if (!in_range(a)) begin
      return '0;
    end
    return front_sel_q ? bank1_q[a] : bank0_q[a];
  endfunction

  assign edit_addr   = edit_pos_q[ADDR_W+4:5];
  assign toggle_mask = {{(BLOCK_LEN-1){1'b0}}, 1'b1} << edit_pos_q[4:0];
  assign vsync_lead  = (vsync_q != VS_ACT) && (vsync == VS_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      swapped_q   <= 1'b0;
      vsync_q     <= ~VS_ACT;
      edit_pos_q  <= '0;
      edit_word_q <= '0;
      vga_live_q  <= '0;
      eng_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swapped_q   <= swapped_d;
      vsync_q     <= vsync;
      edit_pos_q  <= edit_pos_d;
      edit_word_q <= edit_word_d;
      vga_live_q  <= rd_front(vga_addr);
      eng_rd_q    <= rd_front(eng_rd_addr);
    end
  end

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swapped_d   = 1'b0;
    edit_pos_d  = edit_pos_q;
    edit_word_d = edit_word_q;
    case (state_q)
      S_IDLE: begin
        if (edit_req) begin
          state_d    = S_EDIT_RD;
          edit_pos_d = edit_pos;
        end else if (eng_start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (eng_done) begin
          state_d = S_SWAP_WAIT;
        end
      end
      S_SWAP_WAIT: begin
        if (vsync_lead) begin
          front_sel_d = ~front_sel_q;
          swapped_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_EDIT_RD: begin
        edit_word_d = rd_front(edit_addr);
        state_d     = S_EDIT_WR;
      end
      S_EDIT_WR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    eng_busy = (state_q == S_RUN);
    wr_en    = 1'b0;
    wr_bank  = ~front_sel_q;
    wr_addr  = eng_wr_addr;
    wr_data  = eng_wr_data;
    case (state_q)
      S_RUN: begin
        wr_en = eng_wr_en && in_range(eng_wr_addr);
      end
      S_EDIT_WR: begin
        wr_en   = in_range(edit_addr);
        wr_bank = front_sel_q;
        wr_addr = edit_addr;
        wr_data = edit_word_q ^ toggle_mask;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Banks carry no reset so a reset never disturbs the displayed pattern.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) begin
      bank0_q[wr_addr] <= wr_data;
    end
    if (wr_en && wr_bank) begin
      bank1_q[wr_addr] <= wr_data;
    end
  end

  assign vga_live    = vga_live_q;
  assign eng_rd_data = eng_rd_q;
  assign swapped     = swapped_q;
  assign front_sel   = front_sel_q;

endmodule

// File: tb/tb_life_frame_buffer.sv
// tb/tb_life_frame_buffer.sv - self-checking bench for life_frame_buffer
module tb_life_frame_buffer;

  localparam int AW = 10;
  localparam int DP = 1000;

  logic          clk;
  logic          rst;
  logic [AW-1:0] vga_addr;
  logic [31:0]   vga_live;
  logic          vsync;
  logic          eng_start;
  logic          eng_done;
  logic [AW-1:0] eng_rd_addr;
  logic [31:0]   eng_rd_data;
  logic          eng_wr_en;
  logic [AW-1:0] eng_wr_addr;
  logic [31:0]   eng_wr_data;
  logic          edit_req;
  logic [AW+4:0] edit_pos;
  logic          ready;
  logic          eng_busy;
  logic          swapped;
  logic          front_sel;

  life_frame_buffer #(
    .ADDR_W   (AW),
    .DEPTH    (DP),
    .BLOCK_LEN(32),
    .VSPP     (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_addr   (vga_addr),
    .vga_live   (vga_live),
    .vsync      (vsync),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_rd_addr(eng_rd_addr),
    .eng_rd_data(eng_rd_data),
    .eng_wr_en  (eng_wr_en),
    .eng_wr_addr(eng_wr_addr),
    .eng_wr_data(eng_wr_data),
    .edit_req   (edit_req),
    .edit_pos   (edit_pos),
    .ready      (ready),
    .eng_busy   (eng_busy),
    .swapped    (swapped),
    .front_sel  (front_sel)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   exp;
  } rd_vec_t;

  rd_vec_t     vecs_a [7];
  rd_vec_t     vecs_b [9];
  logic [31:0] exp_q [$];
  int          n_vec;
  int          n_err;
  int          swaps;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic present(input logic [AW-1:0] a, input logic [31:0] exp);
    vga_addr    = a;
    eng_rd_addr = a;
    exp_q.push_back(exp);
  endtask

  task automatic pop_chk(input string nm);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_vga"}, vga_live, e);
      chk({nm, "_eng"}, eng_rd_data, e);
    end
  endtask

  task automatic step_rd(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
    present(a, exp);
    tick();
    pop_chk(nm);
  endtask

  task automatic eng_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic done);
    eng_wr_en   = 1'b1;
    eng_wr_addr = a;
    eng_wr_data = d;
    eng_done    = done;
    tick();
    eng_wr_en = 1'b0;
    eng_done  = 1'b0;
  endtask

  task automatic do_edit(input logic [AW-1:0] w, input logic [4:0] b,
                         input logic [31:0] old_v, input logic [31:0] new_v);
    edit_req = 1'b1;
    edit_pos = {w, b};
    present(w, old_v);
    tick();
    edit_req = 1'b0;
    pop_chk("edit_req_cyc");
    chk1("edit_rd_ready", ready, 1'b0);
    present(w, old_v);
    tick();
    pop_chk("edit_rd_cyc");
    chk1("edit_wr_ready", ready, 1'b0);
    present(w, old_v);
    tick();
    pop_chk("edit_wr_old");
    chk1("edit_done_ready", ready, 1'b1);
    step_rd(w, new_v, "edit_new");
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_busy", eng_busy, 1'b0);
    chk1("arst_ready", ready, 1'b1);
    chk1("arst_front", front_sel, 1'b0);
    chk1("arst_swapped", swapped, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs_a = '{'{10'd5, 32'hDEADBEEF}, '{10'd6, 32'hCAFEF00D}, '{10'd7, 32'h0},
               '{10'd9, 32'h12345678}, '{10'd0, 32'h0}, '{10'd1000, 32'h0},
               '{10'd1023, 32'h0}};
    vecs_b = '{'{10'd20, 32'h11112222}, '{10'd5, 32'hDEADBEEE}, '{10'd3, 32'h0},
               '{10'd2, 32'h1}, '{10'd9, 32'h12345678}, '{10'd7, 32'h0},
               '{10'd30, 32'h0}, '{10'd6, 32'hCAFEF00D}, '{10'd1000, 32'h0}};

    rst = 1'b1; vsync = 1'b1; eng_start = 1'b0; eng_done = 1'b0;
    vga_addr = '0; eng_rd_addr = '0; eng_wr_en = 1'b0; eng_wr_addr = '0;
    eng_wr_data = '0; edit_req = 1'b0; edit_pos = '0;
    repeat (3) tick();
    chk1("rst_front", front_sel, 1'b0);
    chk1("rst_swapped", swapped, 1'b0);
    chk1("rst_busy", eng_busy, 1'b0);
    chk("rst_vga", vga_live, 32'h0);
    chk("rst_eng_rd", eng_rd_data, 32'h0);
    rst = 1'b0;
    tick();
    chk1("rel_ready", ready, 1'b1);

    // generation 1 into B1
    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    chk1("run_busy", eng_busy, 1'b1);
    chk1("run_ready", ready, 1'b0);
    eng_wr(10'd5, 32'hDEADBEEF, 1'b0);
    eng_wr(10'd9, 32'h12345678, 1'b0);
    eng_wr(10'd6, 32'hCAFEF00D, 1'b1);
    chk1("sw_busy", eng_busy, 1'b0);
    chk1("sw_ready", ready, 1'b0);
    step_rd(10'd5, 32'h0, "back_hidden5");
    step_rd(10'd6, 32'h0, "back_hidden6");

    swaps = 0;
    eng_wr_en = 1'b1; eng_wr_addr = 10'd7; eng_wr_data = 32'hFFFFFFFF;
    repeat (1000) begin
      tick();
      if (swapped) swaps++;
    end
    eng_wr_en = 1'b0;
    chk1("hold_front", front_sel, 1'b0);
    chk1("hold_ready", ready, 1'b0);
    chk("hold_swaps", 32'(swaps), 32'd0);

    vsync = 1'b0;
    present(10'd5, 32'h0);
    tick();
    pop_chk("swap_cyc_old");
    chk1("swap_pulse", swapped, 1'b1);
    chk1("swap_front", front_sel, 1'b1);
    step_rd(10'd5, 32'hDEADBEEF, "swap_first_new");
    chk1("swap_pulse_end", swapped, 1'b0);
    chk1("swap_ready", ready, 1'b1);
    swaps = 0;
    repeat (3) begin
      tick();
      if (swapped) swaps++;
    end
    vsync = 1'b1;
    tick();
    chk("swap_once", 32'(swaps), 32'd0);

    for (int i = 0; i < 7; i++) begin
      step_rd(vecs_a[i].addr, vecs_a[i].exp, "table_a");
    end

    do_edit(10'd3, 5'd31, 32'h0, 32'h80000000);
    do_edit(10'd3, 5'd31, 32'h80000000, 32'h0);
    do_edit(10'd5, 5'd0, 32'hDEADBEEF, 32'hDEADBEEE);
    do_edit(10'd1000, 5'd4, 32'h0, 32'h0);

    // edit wins over a simultaneous start
    edit_req = 1'b1; eng_start = 1'b1; edit_pos = {10'd2, 5'd0};
    tick();
    edit_req = 1'b0; eng_start = 1'b0;
    chk1("both_busy0", eng_busy, 1'b0);
    chk1("both_ready0", ready, 1'b0);
    tick();
    chk1("both_busy1", eng_busy, 1'b0);
    tick();
    chk1("both_busy2", eng_busy, 1'b0);
    chk1("both_ready2", ready, 1'b1);
    step_rd(10'd2, 32'h1, "both_edit");
    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    chk1("late_start_busy", eng_busy, 1'b1);

    // mid-RUN reset: back bank B0 write must survive
    eng_wr(10'd11, 32'hA5A5A5A5, 1'b0);
    eng_wr(10'd1000, 32'hFFFFFFFF, 1'b0);
    async_reset();
    tick();
    step_rd(10'd11, 32'hA5A5A5A5, "b0_kept11");
    step_rd(10'd5, 32'h0, "b0_addr5");
    step_rd(10'd1000, 32'h0, "b0_oor");

    // mid-SWAP_WAIT reset
    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    eng_wr(10'd20, 32'h11112222, 1'b1);
    chk1("sw2_ready", ready, 1'b0);
    async_reset();
    tick();
    vsync = 1'b0;
    tick();
    chk1("idle_vs_swapped", swapped, 1'b0);
    vsync = 1'b1;
    tick();
    chk1("idle_vs_front", front_sel, 1'b0);

    eng_wr_en = 1'b1; eng_wr_addr = 10'd30; eng_wr_data = 32'h55555555; eng_done = 1'b1;
    tick();
    eng_wr_en = 1'b0; eng_done = 1'b0;
    chk1("idle_done_ready", ready, 1'b1);

    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    vsync = 1'b0;
    tick();
    chk1("g3_swap", swapped, 1'b1);
    chk1("g3_front", front_sel, 1'b1);
    vsync = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      step_rd(vecs_b[i].addr, vecs_b[i].exp, "table_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
